// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, legal oversampling
// ratios and the default word width.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic is_legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Per-bit oversampling counter and three-point majority vote around mid-bit.
module uart_rx_data_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       cnt_clr,
  output logic       bit_value,
  output logic       sample_tick,
  output logic       bit_done
);

  logic [5:0] edge_cnt;
  logic [5:0] half;
  logic       s0;
  logic       s1;

  assign half        = {1'b0, prescale[5:1]};
  assign sample_tick = (edge_cnt == half + 6'd1);
  assign bit_done    = (edge_cnt == prescale - 6'd1);
  // The third vote is the live line value, so the result is usable on the tick itself.
  assign bit_value   = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
    end else begin
      if (cnt_clr || bit_done) edge_cnt <= '0;
      else                     edge_cnt <= edge_cnt + 6'd1;
      if (edge_cnt == half - 6'd1) s0 <= RX_IN;
      if (edge_cnt == half)        s1 <= RX_IN;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: frame FSM, deserializer, parity and stop checking.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Data_width = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [Data_width-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BCW = (Data_width > 1) ? $clog2(Data_width) : 1;

  logic [2:0]            state, state_nxt;
  logic [BCW-1:0]        bit_cnt;
  logic [Data_width-1:0] shift_reg;
  logic [5:0]            prescale_q;
  logic                  par_en_q, par_typ_q;
  logic                  par_flag, stop_bit;
  logic                  bit_value, sample_tick, bit_done;
  logic                  last_bit, start_det, cnt_clr;

  assign last_bit  = (bit_cnt == BCW'(Data_width - 1));
  assign start_det = !RX_IN && ((state == ST_IDLE) || (state == ST_STOP && bit_done));
  // Holding the counter at 0 in IDLE makes edge_cnt = 0 on the first START cycle.
  assign cnt_clr   = (state == ST_IDLE) || (state_nxt == ST_IDLE);

  uart_rx_data_sampler u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .prescale   (prescale_q),
    .cnt_clr    (cnt_clr),
    .bit_value  (bit_value),
    .sample_tick(sample_tick),
    .bit_done   (bit_done)
  );

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!RX_IN) state_nxt = ST_START;
      ST_START: begin
        if (sample_tick && bit_value) state_nxt = ST_IDLE;
        else if (bit_done)            state_nxt = ST_DATA;
      end
      ST_DATA:   if (bit_done && last_bit) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) state_nxt = ST_STOP;
      ST_STOP:   if (bit_done) state_nxt = RX_IN ? ST_IDLE : ST_START;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      prescale_q   <= PRESCALE_8;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_flag     <= 1'b0;
      stop_bit     <= 1'b1;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      state        <= state_nxt;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;

      // An illegal ratio falls back to 8 so the counters always wrap in range.
      if (start_det) begin
        prescale_q <= is_legal_prescale(Prescale) ? Prescale : PRESCALE_8;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        par_flag   <= 1'b0;
        bit_cnt    <= '0;
      end

      if (state == ST_DATA) begin
        if (sample_tick) shift_reg <= {bit_value, shift_reg[Data_width-1:1]};
        if (bit_done)    bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
      end

      if (state == ST_PARITY && sample_tick)
        par_flag <= (bit_value != ((^shift_reg) ^ par_typ_q));

      if (state == ST_STOP && sample_tick) stop_bit <= bit_value;

      if (state == ST_STOP && bit_done) begin
        if (par_flag)      parity_error <= 1'b1;
        else if (!stop_bit) stop_error  <= 1'b1;
        else begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver and the counterpart of the system's UART transmitter. It oversamples the serial line `RX_IN` at `Prescale` clocks per bit, detects the start bit with glitch rejection, and majority-votes three mid-bit samples. It deserializes `Data_width` bits LSB first, checks the optional parity bit and the stop bit, then presents the word on `P_DATA` with a one-cycle `data_valid` strobe toward the system controller.

## Interface
- `Data_width`, 8, number of data bits per frame.
- `CLK` input 1: oversampling clock; all logic is on the rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `RX_IN` input 1: serial line, idle high, already synchronous to `CLK`.
- `Prescale` input 6: clocks per bit; legal values are 8, 16 and 32.
- `PAR_EN` input 1: 1 means a parity bit follows the data.
- `PAR_TYP` input 1: 0 is even parity, 1 is odd parity.
- `P_DATA` output `Data_width`: last correctly received word.
- `data_valid` output 1: one-cycle strobe meaning `P_DATA` was just updated.
- `parity_error` output 1: one-cycle strobe at the end of a frame with bad parity.
- `stop_error` output 1: one-cycle strobe at the end of a frame with a stop bit of 0.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Counters:** `edge_cnt` runs 0..Prescale-1 within a bit. `bit_cnt` runs 0..Data_width-1 in DATA.
- **Sampled bit value:** majority of `RX_IN` at `edge_cnt` = P/2-1, P/2 and P/2+1, where P = Prescale.
- **Per-frame latching:** `Prescale`, `PAR_EN` and `PAR_TYP` are latched on the start-detect cycle. Changes during a frame take effect on the next frame.
- **IDLE:** `RX_IN` sampled 0 moves to START with `edge_cnt` = 0.
- **START:**
  - If the sampled bit value is 1 (glitch), return to IDLE at `edge_cnt` = P/2+1; no strobe.
  - Otherwise, at `edge_cnt` = P-1 go to DATA.
- **DATA:**
  - Each sampled bit value shifts into an internal shift register, LSB first.
  - After bit `Data_width`-1 ends, go to PARITY if `PAR_EN`, else to STOP.
- **PARITY:** expected parity bit = XOR of the data bits for even parity, or its inverse for odd. A mismatch sets an internal error flag.
- **STOP:** at `edge_cnt` = P-1, evaluate:
  - Parity flag set: pulse `parity_error`. This takes priority; `stop_error` is not raised in the same frame.
  - Otherwise, stop bit value 0: pulse `stop_error`.
  - Otherwise: load `P_DATA` from the shift register and pulse `data_valid`.
- **Next state after STOP:** START if `RX_IN` = 0 on that same cycle (back-to-back frames), else IDLE.
- **Error frames:** `P_DATA` keeps its previous value.
- **Illegal `Prescale`:** values other than 8/16/32 give unspecified data. The FSM must still return to IDLE within one frame length and never lock up.

## Timing
- **Reset values:** FSM in IDLE, all counters 0. Outputs `P_DATA` = 0, `data_valid` = 0, `parity_error` = 0, `stop_error` = 0.
- **Reset mid-frame:** abort immediately. No strobe is produced after reset is released.
- **Frame length:** N = 10 bits without parity, 11 with parity.
- **Strobe latency:** let the start-detect edge be cycle k. The end-of-frame strobe (`data_valid`, `parity_error` or `stop_error`) is high exactly during cycle k+N·P to k+N·P+1.
- **Strobe rules:** every strobe is exactly one cycle wide, and at most one strobe is asserted per frame.
- **Back-to-back frames:** a new start bit may begin in the cycle after the stop bit ends with zero idle gap. Consecutive strobes are then N·P cycles apart.
- **Glitch rejection:** a low pulse shorter than P/2-1 cycles produces no strobe. The FSM is back in IDLE no later than k+P/2+2.
- **`P_DATA` update:** changes only in the same cycle `data_valid` rises.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enumeration.
  - Legal prescale constants (8, 16, 32).
  - Default `Data_width`.
- **Sub-module `uart_rx_data_sampler`:** `edge_cnt` plus 3-sample majority vote. Outputs the sampled bit value and a "bit done" flag at `edge_cnt` = P-1.
- **Top level:** the FSM, `bit_cnt`, the deserializer shift register and parity/stop checking.

## Test plan
- **Valid frame, no parity:** P=8, `PAR_EN`=0, frame 0,10100101,1 (LSB first, 8'hA5) → `P_DATA`=8'hA5 with `data_valid` high one cycle at k+80; no error strobes.
- **Parity on, even and odd:** P=16, data 8'h48, parity bit 0, `PAR_TYP`=0 → `data_valid`, `P_DATA`=8'h48. Repeat with `PAR_TYP`=1 and parity bit 1 → `data_valid`. Repeat with `PAR_TYP`=1 and parity bit 0 → `parity_error` at k+176; `P_DATA` stays 8'h48.
- **Stop error:** P=8, data 8'hFF, stop bit driven 0 → `stop_error` one cycle at k+80; `data_valid` stays 0; `P_DATA` unchanged.
- **Glitch rejection:** P=16, `RX_IN` low for 3 cycles then high → no strobe; FSM in IDLE by k+10; a following valid 8'h3C frame is received correctly.
- **Back-to-back frames:** P=32, 8'h00 then 8'hFF with no idle gap → two `data_valid` pulses exactly 320 cycles apart with correct data.
- **Reset mid-frame:** assert `RST`=0 during bit 4 of a frame → all outputs 0 immediately. After release, the line held idle gives no strobe, and the next 8'h5A frame gives `data_valid` with 8'h5A.
